tcn_actmem_scheduler: RTL
=========================

// Module: tcn_actmem_scheduler
// PURPOSE
// - Sequencer/arbiter in front of the TCN activation memory (tcn shift memory + decoders).
// - Shares the memory between the output write-back path (one time step per write) and the
//   compute read path (K dilated taps per read).
// - Tracks ring head and fill level; drives set/read/write shift config, bank enables,
//   addresses and left shift.
// - Write has priority; a read never collides in the memory because the scheduler holds it off.
// PARAMETERS
// - K              3                        taps per convolution step
// - WEIGHT_STAGGER 8                        words per time step (banks per tap)
// - NUMBANKS       K*WEIGHT_STAGGER         memory banks driven
// - TCN_WIDTH      24                       ring depth in time steps
// - SHW            $clog2(TCN_WIDTH)        slot/shift width
// - LSW            $clog2(NUMBANKS)         left-shift width
// PORTS
// - clk_i               in   1              clock
// - rst_ni              in   1              asynchronous reset, active-low
// - cfg_valid_i         in   1              load new layer config
// - cfg_ready_o         out  1              config accepted this cycle
// - cfg_dilation_i      in   SHW            tap spacing d, 1..TCN_WIDTH-1
// - cfg_shift_i         in   SHW            shift depth forwarded to memory on config
// - flush_i             in   1              clear fill level and head, keep config
// - wr_valid_i          in   1              write-back time step available
// - wr_ready_o          out  1              write accepted
// - wr_word_mask_i      in   WEIGHT_STAGGER words present in this time step
// - rd_valid_i          in   1              compute requests the next K-tap window
// - rd_ready_o          out  1              read issued to memory this cycle
// - rd_data_valid_o     out  1              acts_o of memory valid (1 cycle after issue)
// - mem_read_enable_o   out  NUMBANKS       per-bank read enable
// - mem_write_enable_o  out  NUMBANKS       per-bank write enable
// - mem_addr_o          out  NUMBANKS*SHW   per-bank slot address
// - mem_left_shift_o    out  LSW            output rotation
// - mem_set_shift_o     out  1              pulse: apply read/write shift
// - mem_read_shift_o    out  SHW            read shift depth
// - mem_write_shift_o   out  SHW            write shift depth
// - fill_o              out  SHW+1          time steps currently held
// BEHAVIOUR
// - Reset: every output 0; FSM IDLE, head=0, fill=0, dilation=1.
// - FSM: IDLE -> (cfg_valid_i) CFG -> RUN; RUN -> (cfg_valid_i && no read in flight) CFG.
//   cfg_ready_o=1 only in IDLE, or RUN with rd_data_valid_o low next cycle.
// - CFG (1 cycle): mem_set_shift_o=1; read/write shift = cfg_shift_i; dilation latched;
//   head=fill=0; rd/wr ready low.
// - Write (RUN, wr_valid_i): wr_ready_o=1 combinationally.
//   mem_write_enable_o[j] = wr_word_mask_i[j] for j<WEIGHT_STAGGER, others 0.
//   Address = head; head <= (head+1) mod TCN_WIDTH; fill saturates at TCN_WIDTH
//   (oldest step is overwritten when full, no error).
// - Read eligible: RUN && !wr_valid_i && fill >= (K-1)*d+1 (compare in SHW+2 bits).
// - Read issue (rd_valid_i && eligible): rd_ready_o=1. Tap k banks k*WS..k*WS+WS-1 are enabled,
//   addr = (head-1-k*d) mod TCN_WIDTH (wrap by add-TCN_WIDTH, no divider); mem_left_shift_o=0.
// - Simultaneous wr_valid_i and rd_valid_i: write wins, read stalls (rd_ready_o=0);
//   read/write enables are never both set on a bank.
// - rd_data_valid_o registered: 1 exactly one cycle after rd_ready_o.
// - flush_i: head=fill=0 next cycle, overrides a same-cycle write (wr_ready_o=0);
//   a read issued the previous cycle still returns.
// - cfg_valid_i during CFG ignored; reset mid-operation returns to IDLE, drops in-flight read.
// STRUCTURE
// - Package tcn_pkg: sched_state_e {IDLE,CFG,RUN}; slot_t = logic [SHW-1:0];
//   function wrap_sub(a,b) for modular slot arithmetic.
// - One sub-module: tcn_actmem_slot_gen (combinational, K tap addresses from head, d).
// TESTING
// - Reset, cfg d=1 -> mem_set_shift_o pulses once, cfg_ready_o=0 during CFG, fill_o=0.
// - 3 writes mask 8'hFF, then read -> taps at slots 2,1,0; rd_data_valid_o next cycle.
// - d=4, 8 writes -> rd_ready_o stays 0 until fill=9; at head=9 taps 8,4,0.
// - 30 writes, TCN_WIDTH=24 -> fill_o saturates 24, head=6; read d=2 taps 5,3,1.
// - wr_valid_i && rd_valid_i together for 3 cycles -> 3 writes, read on cycle 4,
//   no bank both enables.
// - flush_i with concurrent write -> wr_ready_o=0, fill_o=0 next cycle, read blocked.

Source files
------------

// File: rtl/tcn_pkg.sv
// rtl/tcn_pkg.sv - shared types, sizes and slot arithmetic for the TCN activation memory scheduler
package tcn_pkg;

    localparam int K              = 3;
    localparam int WEIGHT_STAGGER = 8;
    localparam int NUMBANKS       = K * WEIGHT_STAGGER;
    localparam int TCN_WIDTH      = 24;
    localparam int SHW            = $clog2(TCN_WIDTH);
    localparam int LSW            = $clog2(NUMBANKS);

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        RUN
    } sched_state_e;

    typedef logic [SHW-1:0] slot_t;

    // (a - b) mod TCN_WIDTH for b < 2*TCN_WIDTH, using conditional subtracts instead of a divider
    function automatic slot_t wrap_sub(input slot_t a, input logic [SHW+1:0] b);
        logic [SHW+2:0] t;
        t = {3'b000, a} + (SHW+3)'(2 * TCN_WIDTH) - {1'b0, b};
        if (t >= (SHW+3)'(TCN_WIDTH)) t = t - (SHW+3)'(TCN_WIDTH);
        if (t >= (SHW+3)'(TCN_WIDTH)) t = t - (SHW+3)'(TCN_WIDTH);
        return t[SHW-1:0];
    endfunction

    // Time steps needed before a full K-tap window exists: (K-1)*d + 1
    function automatic logic [SHW+1:0] read_need(input slot_t d);
        logic [SHW+1:0] n;
        n = (SHW+2)'(1);
        for (int k = 1; k < K; k++) begin
            n = n + {2'b00, d};
        end
        return n;
    endfunction

endpackage

// File: rtl/tcn_actmem_slot_gen.sv
// rtl/tcn_actmem_slot_gen.sv - K dilated tap slot addresses behind the ring head
module tcn_actmem_slot_gen
    import tcn_pkg::*;
(
    input  logic [SHW-1:0]   head_i,
    input  logic [SHW-1:0]   dilation_i,
    output logic [K*SHW-1:0] tap_addr_o
);

    logic [SHW+1:0] off;

    // Tap k sits at head-1-k*d; the offset is accumulated so no multiplier is needed
    always_comb begin
        off        = (SHW+2)'(1);
        tap_addr_o = '0;
        for (int k = 0; k < K; k++) begin
            tap_addr_o[k*SHW +: SHW] = wrap_sub(head_i, off);
            off = off + {2'b00, dilation_i};
        end
    end

endmodule

// File: rtl/tcn_actmem_scheduler.sv
// rtl/tcn_actmem_scheduler.sv - arbitrates TCN activation memory between write-back and K-tap reads
module tcn_actmem_scheduler
    import tcn_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [SHW-1:0]            cfg_dilation_i,
    input  logic [SHW-1:0]            cfg_shift_i,
    input  logic                      flush_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [WEIGHT_STAGGER-1:0] wr_word_mask_i,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic                      rd_data_valid_o,
    output logic [NUMBANKS-1:0]       mem_read_enable_o,
    output logic [NUMBANKS-1:0]       mem_write_enable_o,
    output logic [NUMBANKS*SHW-1:0]   mem_addr_o,
    output logic [LSW-1:0]            mem_left_shift_o,
    output logic                      mem_set_shift_o,
    output logic [SHW-1:0]            mem_read_shift_o,
    output logic [SHW-1:0]            mem_write_shift_o,
    output logic [SHW:0]              fill_o
);

    sched_state_e   state_q, state_d;
    slot_t          head_q, head_d;
    slot_t          dil_q, dil_d;
    slot_t          shift_q, shift_d;
    logic [SHW:0]   fill_q, fill_d;
    logic           rd_data_valid_q;
    logic           rd_eligible;
    logic [K*SHW-1:0] tap_addr;

    tcn_actmem_slot_gen u_slot_gen (
        .head_i     (head_q),
        .dilation_i (dil_q),
        .tap_addr_o (tap_addr)
    );

    // Reads are held off whenever a write or flush owns the cycle, so banks never see both
    assign rd_eligible = (state_q == RUN) && !wr_valid_i && !flush_i
                         && ({1'b0, fill_q} >= read_need(dil_q));

    always_comb begin
        state_d            = state_q;
        head_d             = head_q;
        fill_d             = fill_q;
        dil_d              = dil_q;
        shift_d            = shift_q;
        cfg_ready_o        = 1'b0;
        wr_ready_o         = 1'b0;
        rd_ready_o         = 1'b0;
        mem_set_shift_o    = 1'b0;
        mem_write_enable_o = '0;
        mem_read_enable_o  = '0;
        mem_addr_o         = '0;

        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    state_d = CFG;
                    dil_d   = cfg_dilation_i;
                    shift_d = cfg_shift_i;
                end
            end
            CFG: begin
                mem_set_shift_o = 1'b1;
                head_d          = '0;
                fill_d          = '0;
                state_d         = RUN;
            end
            RUN: begin
                wr_ready_o  = wr_valid_i && !flush_i;
                rd_ready_o  = rd_valid_i && rd_eligible;
                // Reconfiguring while a read returns would corrupt the data the compute path expects
                cfg_ready_o = !rd_ready_o;
                if (cfg_valid_i && cfg_ready_o) begin
                    state_d = CFG;
                    dil_d   = cfg_dilation_i;
                    shift_d = cfg_shift_i;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_ready_o) begin
            mem_write_enable_o[WEIGHT_STAGGER-1:0] = wr_word_mask_i;
            head_d = (head_q == SHW'(TCN_WIDTH - 1)) ? '0 : head_q + 1'b1;
            fill_d = (fill_q == (SHW+1)'(TCN_WIDTH)) ? fill_q : fill_q + 1'b1;
        end

        if (rd_ready_o) begin
            mem_read_enable_o = '1;
        end

        for (int b = 0; b < NUMBANKS; b++) begin
            if (rd_ready_o) begin
                mem_addr_o[b*SHW +: SHW] = tap_addr[(b / WEIGHT_STAGGER)*SHW +: SHW];
            end else if (wr_ready_o && (b < WEIGHT_STAGGER)) begin
                mem_addr_o[b*SHW +: SHW] = head_q;
            end
        end

        if (flush_i) begin
            head_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            head_q          <= '0;
            fill_q          <= '0;
            dil_q           <= SHW'(1);
            shift_q         <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            fill_q          <= fill_d;
            dil_q           <= dil_d;
            shift_q         <= shift_d;
            rd_data_valid_q <= rd_ready_o;
        end
    end

    assign rd_data_valid_o   = rd_data_valid_q;
    assign mem_left_shift_o  = '0;
    assign mem_read_shift_o  = shift_q;
    assign mem_write_shift_o = shift_q;
    assign fill_o            = fill_q;

endmodule
